// File: rtl/pipeline_issue_ctrl_if.sv
// Handshake and status bundle between the instruction source and the issue controller.
// The source side (master) offers instructions; the controller (slave) issues them.
interface pipeline_issue_ctrl_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   InstrIn;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   InstrOut;
    logic          issue_valid;
    logic          stall;
    logic [CW-1:0] count;
    logic [15:0]   stall_cnt;

    modport master (
        output InstrIn, in_valid,
        input  in_ready, InstrOut, issue_valid, stall, count, stall_cnt
    );

    modport slave (
        input  InstrIn, in_valid,
        output in_ready, InstrOut, issue_valid, stall, count, stall_cnt
    );
endinterface

// File: rtl/pipeline_issue_ctrl.sv
// In-order issue controller: FIFO of R-type instructions, RAW interlock against a
// LAT-deep scoreboard of in-flight destination registers.
module pipeline_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int LAT   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_issue_ctrl_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]        r_mem [DEPTH];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;
    logic [LAT:1]       r_slot_vld;
    logic [LAT:1][4:0]  r_slot_rd;
    logic [31:0]        r_instr_out;
    logic               r_issue_valid;
    logic               r_stall;
    logic [15:0]        r_stall_cnt;

    logic               w_push;
    logic               w_nempty;
    logic               w_match;
    logic               w_hazard;
    logic               w_issue;
    logic [31:0]        w_head;
    logic [4:0]         w_rs;
    logic [4:0]         w_rt;
    logic [4:0]         w_rd;

    assign bus.in_ready    = (r_count != CW'(DEPTH));
    assign bus.InstrOut    = r_instr_out;
    assign bus.issue_valid = r_issue_valid;
    assign bus.stall       = r_stall;
    assign bus.count       = r_count;
    assign bus.stall_cnt   = r_stall_cnt;

    assign w_push   = bus.in_valid && bus.in_ready;
    assign w_nempty = (r_count != '0);
    assign w_head   = r_mem[r_rptr];
    assign w_rs     = w_head[25:21];
    assign w_rt     = w_head[20:16];
    assign w_rd     = w_head[15:11];

    // R0 is never a real source, so it can never match a pending write.
    always_comb begin
        w_match = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            if (r_slot_vld[k] &&
                ((w_rs != 5'd0 && w_rs == r_slot_rd[k]) ||
                 (w_rt != 5'd0 && w_rt == r_slot_rd[k])))
                w_match = 1'b1;
        end
    end

    assign w_hazard = w_nempty && w_match;
    assign w_issue  = w_nempty && !w_hazard;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= bus.InstrIn;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_slot_vld    <= '0;
            r_slot_rd     <= '0;
            r_instr_out   <= '0;
            r_issue_valid <= 1'b0;
            r_stall       <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_issue)
                r_rptr <= r_rptr + 1'b1;

            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            // Scoreboard ages every cycle; only an issue with a real destination arms slot 1.
            for (int k = 2; k <= LAT; k++) begin
                r_slot_vld[k] <= r_slot_vld[k-1];
                r_slot_rd[k]  <= r_slot_rd[k-1];
            end
            r_slot_vld[1] <= w_issue && (w_rd != 5'd0);
            r_slot_rd[1]  <= w_rd;

            r_instr_out   <= w_issue ? w_head : 32'h0;
            r_issue_valid <= w_issue;
            r_stall       <= w_hazard;
            if (w_hazard && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// Bench for pipeline_issue_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a scoreboard-by-timestamp model.
module tb_pipeline_issue_ctrl;
    localparam int DEPTH = 4;
    localparam int LAT   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_issue_ctrl_if #(.DEPTH(DEPTH)) bus ();

    pipeline_issue_ctrl #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int rs, input int rt, input int rd);
        return {6'h0, 5'(rs), 5'(rt), 5'(rd), 11'h0};
    endfunction

    // Model: a queue for the buffer, and for each register the edge number of its
    // most recent issued write; a source is busy while fewer than LAT+1 edges have passed.
    logic [31:0] mq [$];
    int          last_wr [32] = '{default: -100};
    int          mcyc = 0;
    logic [31:0] e_out = '0;
    logic        e_iv = 1'b0;
    logic        e_stall = 1'b0;
    int          e_scnt = 0;
    logic [31:0] m_head;
    logic        m_haz;
    logic        m_push;

    function automatic logic busy(input logic [4:0] r);
        return (r != 5'd0) && (mcyc - last_wr[r] <= LAT);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            foreach (last_wr[i]) last_wr[i] = -100;
            mcyc    = 0;
            e_out   = '0;
            e_iv    = 1'b0;
            e_stall = 1'b0;
            e_scnt  = 0;
        end else begin
            mcyc++;
            m_push = bus.in_valid && (mq.size() != DEPTH);
            m_haz  = 1'b0;
            m_head = '0;
            if (mq.size() != 0) begin
                m_head = mq[0];
                m_haz  = busy(m_head[25:21]) || busy(m_head[20:16]);
            end
            e_stall = m_haz;
            if (m_haz && e_scnt < 65535) e_scnt++;
            if (mq.size() != 0 && !m_haz) begin
                e_out = mq.pop_front();
                e_iv  = 1'b1;
                if (e_out[15:11] != 5'd0) last_wr[e_out[15:11]] = mcyc;
            end else begin
                e_out = '0;
                e_iv  = 1'b0;
            end
            if (m_push) mq.push_back(bus.InstrIn);
        end
    end

    always @(negedge clk) begin
        chk("InstrOut",    bus.InstrOut,           e_out);
        chk("issue_valid", 32'(bus.issue_valid),   32'(e_iv));
        chk("stall",       32'(bus.stall),         32'(e_stall));
        chk("stall_cnt",   32'(bus.stall_cnt),     32'(e_scnt));
        chk("count",       32'(bus.count),         32'(mq.size()));
        chk("in_ready",    32'(bus.in_ready),      32'(mq.size() != DEPTH));
    end

    // Observation log used by the directed literal checks.
    int          tcyc = 0;
    int          iv_tot = 0;
    int          st_tot = 0;
    int          iss_cyc [$];
    logic [31:0] iss_log [$];

    always @(negedge clk) begin
        tcyc++;
        if (bus.issue_valid) begin
            iv_tot++;
            iss_cyc.push_back(tcyc);
            iss_log.push_back(bus.InstrOut);
        end
        if (bus.stall) st_tot++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, output int waited);
        waited = 0;
        bus.in_valid = 1'b1;
        bus.InstrIn  = ins;
        while (!bus.in_ready && waited < 100) begin
            step();
            waited++;
        end
        if (waited >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    int          w;
    int          b_iv;
    int          b_st;
    logic [31:0] exp_ord [6];

    initial begin
        bus.in_valid = 1'b0;
        bus.InstrIn  = '0;
        #1 rst = 1'b0;
        #1;
        chk("rst_InstrOut",  bus.InstrOut,            32'h0);
        chk("rst_iv",        32'(bus.issue_valid),    32'h0);
        chk("rst_count",     32'(bus.count),          32'h0);
        chk("rst_in_ready",  32'(bus.in_ready),       32'h1);
        step();
        step();
        rst = 1'b1;
        step();

        // Independent stream issues back-to-back.
        b_iv = iv_tot;
        b_st = st_tot;
        send(mk(1, 2, 2), w);
        send(mk(3, 4, 4), w);
        send(mk(5, 6, 6), w);
        send(mk(7, 8, 8), w);
        repeat (3) step();
        chk("ind_issues",  32'(iv_tot - b_iv), 32'd4);
        chk("ind_stalls",  32'(st_tot - b_st), 32'd0);
        chk("ind_b2b",     32'(iss_cyc[$] - iss_cyc[$-3]), 32'd3);

        // RAW on R2: three bubbles.
        send(32'b000000_00010_00001_00010_00000000000, w);
        send(mk(2, 3, 4), w);
        repeat (6) step();
        chk("raw_gap",       32'(iss_cyc[$] - iss_cyc[$-1]), 32'd4);
        chk("raw_stall_cnt", 32'(bus.stall_cnt), 32'd3);

        // Writes to R0 never create a dependency.
        send(mk(3, 3, 0), w);
        send(mk(0, 0, 5), w);
        repeat (3) step();
        chk("r0_gap",       32'(iss_cyc[$] - iss_cyc[$-1]), 32'd1);
        chk("r0_stall_cnt", 32'(bus.stall_cnt), 32'd3);

        // Fill the buffer behind a stalled head.
        exp_ord[0] = mk(1, 1, 9);
        exp_ord[1] = mk(9, 1, 10);
        exp_ord[2] = mk(2, 2, 11);
        exp_ord[3] = mk(3, 3, 12);
        exp_ord[4] = mk(4, 4, 13);
        exp_ord[5] = mk(5, 5, 14);
        for (int i = 0; i < 5; i++) send(exp_ord[i], w);
        chk("full_count", 32'(bus.count),    32'd4);
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        send(exp_ord[5], w);
        chk("full_wait",  32'(w), 32'd1);
        repeat (8) step();
        for (int i = 0; i < 6; i++)
            chk("full_order", iss_log[iss_log.size() - 6 + i], exp_ord[i]);
        chk("full_stall_cnt", 32'(bus.stall_cnt), 32'd6);

        // Asynchronous reset with a populated buffer and a live scoreboard slot.
        send(mk(1, 1, 7), w);
        send(mk(7, 7, 8), w);
        send(mk(3, 3, 10), w);
        send(mk(3, 3, 11), w);
        chk("pre_rst_count", 32'(bus.count), 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("arst_InstrOut",  bus.InstrOut,          32'h0);
        chk("arst_iv",        32'(bus.issue_valid),  32'h0);
        chk("arst_stall",     32'(bus.stall),        32'h0);
        chk("arst_stall_cnt", 32'(bus.stall_cnt),    32'h0);
        chk("arst_count",     32'(bus.count),        32'h0);
        chk("arst_in_ready",  32'(bus.in_ready),     32'h1);
        step();
        step();
        rst = 1'b1;
        b_iv = iv_tot;
        step();
        step();
        chk("post_rst_count",  32'(bus.count), 32'd0);
        chk("post_rst_no_iss", 32'(iv_tot - b_iv), 32'd0);
        b_st = st_tot;
        send(mk(7, 7, 15), w);
        repeat (3) step();
        chk("post_rst_stall", 32'(st_tot - b_st), 32'd0);
        chk("post_rst_instr", iss_log[$], mk(7, 7, 15));

        // Randomized traffic with a small register window to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            bus.in_valid = ($urandom_range(0, 9) < 6);
            bus.InstrIn  = {6'h0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7)), 11'($urandom)};
            if (i == 300) rst = 1'b0;
            if (i == 303) rst = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_issue_ctrl.md
PIPELINE_ISSUE_CTRL -- requirements
Module: pipeline_issue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4: instruction buffer entries, power of 2, range 2..16.
REQ-002 SHALL have parameter LAT, default 3: cycles from issue until the destination register is readable, range 1..8.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port InstrIn, input, 32 bits: R-type instruction; rs=[25:21], rt=[20:16], rd=[15:11].
REQ-006 SHALL have port in_valid, input, 1 bit: InstrIn is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the buffer accepts; a transfer occurs on any edge where in_valid and in_ready are both 1.
REQ-008 SHALL have port InstrOut, output, 32 bits: registered instruction to the pipeline; 32'h0 is a bubble.
REQ-009 SHALL have port issue_valid, output, 1 bit: registered; InstrOut carries a real instruction.
REQ-010 SHALL have port stall, output, 1 bit: registered; the previous cycle withheld a non-empty head because of a hazard.
REQ-011 SHALL have port count, output, clog2(DEPTH)+1 bits: buffer occupancy.
REQ-012 SHALL have port stall_cnt, output, 16 bits: hazard-stall cycles, saturating at 16'hFFFF.

Function
REQ-013 SHALL buffer accepted instructions in a DEPTH-entry FIFO; in_ready = (count != DEPTH), independent of same-cycle issue.
REQ-014 SHALL track in-flight writes in a LAT-slot shift register of {valid, rd}, shifting every cycle; slot 1 loads {issue, rd of the issued instruction}.
REQ-015 SHALL treat a write with rd==0 as no write (slot valid = 0).
REQ-016 SHALL raise hazard (combinational) when the FIFO is non-empty and head rs or rt (nonzero) equals rd in any valid slot 1..LAT.
REQ-017 SHALL set issue = non-empty AND NOT hazard; on issue, pop the head and register InstrOut <= head, issue_valid <= 1.
REQ-018 SHALL otherwise register InstrOut <= 32'h0 and issue_valid <= 0.
REQ-019 SHALL register stall <= hazard; stall_cnt SHALL increment on each edge where hazard = 1, until saturated.
REQ-020 SHALL make an instruction pushed into an empty FIFO available for issue no earlier than the following edge; minimum InstrIn-to-InstrOut latency is 2 edges.
REQ-021 SHALL, for a producer issued at edge t, allow a dependent instruction to issue no earlier than edge t+LAT+1, i.e. exactly LAT bubbles back-to-back.
REQ-022 SHALL maintain count correctly on simultaneous push and pop: count unchanged, FIFO order preserved.
REQ-023 SHALL wrap FIFO read and write pointers modulo DEPTH with no lost or duplicated entries.
REQ-024 SHALL leave the in-flight slots unchanged by a push to the FIFO; only issue loads slot 1.

Reset
REQ-025 SHALL, while rst = 0, force InstrOut = 0, issue_valid = 0, stall = 0, stall_cnt = 0, count = 0, all slots invalid, and pointers = 0, regardless of clk.
REQ-026 SHALL drive in_ready = 1 during and after reset while count = 0.
REQ-027 SHALL drop buffered and in-flight instructions on a reset asserted mid-operation; no instruction issues after reset release until a new one is accepted.

Verification
REQ-028 SHALL cover independent stream: push R1,R2->R2; R3,R4->R4; R5,R6->R6; R7,R8->R8 on consecutive edges -> four issue_valid=1 cycles back-to-back, stall never 1.
REQ-029 SHALL cover RAW, LAT=3: push 32'b000000_00010_00001_00010_00000000000, then rs=2,rt=3,rd=4 -> second issues 4 edges after the first, three bubbles, stall_cnt=3.
REQ-030 SHALL cover R0 exemption: push rd=0, then an instruction reading R0 -> issued back-to-back with no stall.
REQ-031 SHALL cover full buffer: hold a hazard and push DEPTH+1 instructions -> in_ready=0 at count=4; 5th accepted only after the hazard clears and a pop occurs; FIFO order preserved through pointer wrap.
REQ-032 SHALL cover mid-operation reset: assert rst=0 asynchronously between edges with count=3 and a slot valid -> outputs zero immediately; after release, count=0 and an instruction reading the prior rd issues without stall.
